// File: rtl/narrow_axi_mem_responder.sv
// Purpose: AXI4 subordinate on the cluster narrow port backed by a flop word array.
// Latency: R beat 1 cycle after AR handshake; B 1 cycle after W-last handshake.
// Backpressure: one transaction at a time; R/B held stable until r_ready/b_ready.

package narrow_axi_mem_responder_pkg;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 48;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;

    typedef struct packed {
        logic [IW-1:0]   id;
        logic [AW-1:0]   addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            lock;
        logic [3:0]      cache;
        logic [2:0]      prot;
        logic [3:0]      qos;
        logic [3:0]      region;
        logic [5:0]      atop;
        logic [UW-1:0]   user;
    } aw_chan_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
        logic [UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IW-1:0]   id;
        logic [1:0]      resp;
        logic [UW-1:0]   user;
    } b_chan_t;

    typedef struct packed {
        logic [IW-1:0]   id;
        logic [AW-1:0]   addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            lock;
        logic [3:0]      cache;
        logic [2:0]      prot;
        logic [3:0]      qos;
        logic [3:0]      region;
        logic [UW-1:0]   user;
    } ar_chan_t;

    typedef struct packed {
        logic [IW-1:0]   id;
        logic [DW-1:0]   data;
        logic [1:0]      resp;
        logic            last;
        logic [UW-1:0]   user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_resp_t;

endpackage

module narrow_axi_mem_responder #(
    parameter type                    axi_req_t  = narrow_axi_mem_responder_pkg::axi_req_t,
    parameter type                    axi_resp_t = narrow_axi_mem_responder_pkg::axi_resp_t,
    parameter int unsigned            DataWidth  = 64,
    parameter int unsigned            AddrWidth  = 48,
    parameter int unsigned            IdWidth    = 4,
    parameter logic [AddrWidth-1:0]   BaseAddr   = '0,
    parameter int unsigned            NumWords   = 256
) (
    input  logic      soc_clk_i,
    input  logic      rst_i,
    input  axi_req_t  req_i,
    output axi_resp_t resp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] RangeBytes = AddrWidth'(NumWords * StrbWidth);

    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespSlv   = 2'b10;
    localparam logic [1:0] RespDec   = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                state_q, state_d;
    logic [IdWidth-1:0]    id_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  dec_q;      // sticky out-of-range flag for B
    logic                  slv_q;      // sticky slave-error flag
    logic                  noacc_q;    // burst must not touch the array
    logic                  prio_wr_q;  // write wins the next AW/AR collision
    logic [DataWidth-1:0]  mem_q [NumWords];

    logic                  borrow;
    logic [AddrWidth-1:0]  off;
    logic                  in_range;
    logic [IdxW-1:0]       idx;
    logic [AddrWidth-1:0]  next_addr;
    logic                  grant_w, grant_r;
    logic                  aw_hs, ar_hs, w_hs, r_hs;
    logic                  beat_last;
    logic                  aw_bad, ar_bad;
    logic                  unused_ok;

    // The borrow bit catches addresses below BaseAddr without a constant compare.
    assign {borrow, off} = {1'b0, addr_q} - {1'b0, BaseAddr};
    assign in_range      = !borrow && (off < RangeBytes);
    assign idx           = off[OffW +: IdxW];
    assign next_addr     = (burst_q == BurstIncr) ? addr_q + (AddrWidth'(1) << size_q) : addr_q;
    assign beat_last     = (cnt_q == len_q);

    // Collision goes to whichever channel lost last time; lone valids always win.
    assign grant_w = req_i.aw_valid && (!req_i.ar_valid || prio_wr_q);
    assign grant_r = req_i.ar_valid && (!req_i.aw_valid || !prio_wr_q);
    assign aw_hs   = (state_q == IDLE) && !rst_i && grant_w;
    assign ar_hs   = (state_q == IDLE) && !rst_i && grant_r;
    assign w_hs    = (state_q == WDATA) && req_i.w_valid;
    assign r_hs    = (state_q == RDATA) && req_i.r_ready;

    // WRAP and the reserved burst code both have bit 1 set; neither accesses the array.
    assign aw_bad = req_i.aw.burst[1] || (req_i.aw.size > 3'(OffW)) || (req_i.aw.atop != '0);
    assign ar_bad = req_i.ar.burst[1] || (req_i.ar.size > 3'(OffW));

    assign unused_ok = ^{req_i.aw.lock, req_i.aw.cache, req_i.aw.prot, req_i.aw.qos,
                         req_i.aw.region, req_i.aw.user, req_i.w.user,
                         req_i.ar.lock, req_i.ar.cache, req_i.ar.prot, req_i.ar.qos,
                         req_i.ar.region, req_i.ar.user};

    // State register; reset abandons any burst in flight.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and all channel outputs.
    always_comb begin
        state_d = state_q;
        resp_o  = '0;
        case (state_q)
            IDLE: begin
                resp_o.aw_ready = !rst_i && grant_w;
                resp_o.ar_ready = !rst_i && grant_r;
                if (aw_hs)      state_d = WDATA;
                else if (ar_hs) state_d = RDATA;
            end
            WDATA: begin
                resp_o.w_ready = 1'b1;
                if (req_i.w_valid && req_i.w.last) state_d = WRESP;
            end
            WRESP: begin
                resp_o.b_valid = 1'b1;
                resp_o.b.id    = id_q;
                resp_o.b.resp  = dec_q ? RespDec : (slv_q ? RespSlv : RespOkay);
                if (req_i.b_ready) state_d = IDLE;
            end
            RDATA: begin
                resp_o.r_valid = 1'b1;
                resp_o.r.id    = id_q;
                resp_o.r.last  = beat_last;
                resp_o.r.data  = (in_range && !noacc_q) ? mem_q[idx] : '0;
                resp_o.r.resp  = !in_range ? RespDec : (slv_q ? RespSlv : RespOkay);
                if (req_i.r_ready && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context: captured on AW/AR, advanced on every data beat.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            noacc_q   <= 1'b0;
            prio_wr_q <= 1'b1;
        end else if (aw_hs) begin
            id_q      <= req_i.aw.id;
            addr_q    <= req_i.aw.addr;
            len_q     <= req_i.aw.len;
            size_q    <= req_i.aw.size;
            burst_q   <= req_i.aw.burst;
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            slv_q     <= aw_bad;
            noacc_q   <= aw_bad;
            prio_wr_q <= 1'b0;
        end else if (ar_hs) begin
            id_q      <= req_i.ar.id;
            addr_q    <= req_i.ar.addr;
            len_q     <= req_i.ar.len;
            size_q    <= req_i.ar.size;
            burst_q   <= req_i.ar.burst;
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            slv_q     <= ar_bad;
            noacc_q   <= ar_bad;
            prio_wr_q <= 1'b1;
        end else if (w_hs) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            if (!in_range) dec_q <= 1'b1;
            // last either early or missing at the len position
            if (req_i.w.last != beat_last) slv_q <= 1'b1;
        end else if (r_hs) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    // Word array: cleared on reset, strobed byte writes for in-range legal beats.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumWords); i++) mem_q[i] <= '0;
        end else if (w_hs && in_range && !noacc_q) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (req_i.w.strb[b]) mem_q[idx][b*8 +: 8] <= req_i.w.data[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_narrow_axi_mem_responder.sv
// Purpose: randomized + directed bench for narrow_axi_mem_responder against a burst-level model.
// Latency: checks first R beat and B one cycle after the triggering handshake.
// Backpressure: drives random/toggling r_ready, delayed b_ready and W gaps.

module tb_narrow_axi_mem_responder;
    import narrow_axi_mem_responder_pkg::*;

    localparam logic [47:0] BASE  = 48'h1000;
    localparam logic [47:0] RANGE = 48'd2048;
    localparam int          NW    = 256;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic      clk = 1'b0;
    logic      rst;
    axi_req_t  req;
    axi_resp_t resp;

    always #5 clk = ~clk;

    narrow_axi_mem_responder #(
        .axi_req_t (axi_req_t),
        .axi_resp_t(axi_resp_t),
        .DataWidth (64),
        .AddrWidth (48),
        .IdWidth   (4),
        .BaseAddr  (BASE),
        .NumWords  (NW)
    ) dut (
        .soc_clk_i(clk),
        .rst_i    (rst),
        .req_i    (req),
        .resp_o   (resp)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] ref_mem [NW];

    // current transaction
    logic [3:0]  t_id;
    logic [47:0] t_addr;
    logic [7:0]  t_len;
    logic [2:0]  t_size;
    logic [1:0]  t_burst;
    logic [5:0]  t_atop;
    int          t_lastpos;
    logic [63:0] t_wdata [256];
    logic [7:0]  t_wstrb [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    task automatic give_up(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no handshake, expected one within budget", tag);
        print_summary();
        $finish;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [47:0] beat_addr(input int i);
        if (t_burst != INCR) return t_addr;
        return t_addr + (48'(i) << t_size);
    endfunction

    function automatic bit in_rng(input logic [47:0] a);
        return (a >= BASE) && ((a - BASE) < RANGE);
    endfunction

    function automatic int widx(input logic [47:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic bit no_acc();
        return (t_burst == WRAP) || (t_burst == 2'b11) || (t_size > 3'd3) || (t_atop != 6'd0);
    endfunction

    function automatic logic [1:0] exp_bresp();
        bit dec = 1'b0;
        for (int i = 0; i <= t_lastpos; i++) if (!in_rng(beat_addr(i))) dec = 1'b1;
        if (dec) return 2'b11;
        if (no_acc() || t_lastpos != int'(t_len)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_t(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        t_id = id; t_addr = addr; t_len = len; t_size = size; t_burst = burst;
        t_atop = 6'd0; t_lastpos = int'(len);
        for (int i = 0; i < 256; i++) begin
            t_wdata[i] = {$urandom, $urandom};
            t_wstrb[i] = 8'hFF;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("rst_outs", {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid}, 0);
        req = '0;
        rst = 1'b0;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    endtask

    task automatic drive_aw();
        req.aw       = '0;
        req.aw.id    = t_id;
        req.aw.addr  = t_addr;
        req.aw.len   = t_len;
        req.aw.size  = t_size;
        req.aw.burst = t_burst;
        req.aw.atop  = t_atop;
        req.aw_valid = 1'b1;
    endtask

    task automatic drive_ar();
        req.ar       = '0;
        req.ar.id    = t_id;
        req.ar.addr  = t_addr;
        req.ar.len   = t_len;
        req.ar.size  = t_size;
        req.ar.burst = t_burst;
        req.ar_valid = 1'b1;
    endtask

    task automatic aw_phase();
        int k = 0;
        drive_aw();
        #1;
        while (!resp.aw_ready) begin
            if (++k > 40) give_up("aw_wait");
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        req.aw_valid = 1'b0;
    endtask

    task automatic ar_phase();
        int k = 0;
        drive_ar();
        #1;
        while (!resp.ar_ready) begin
            if (++k > 40) give_up("ar_wait");
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        req.ar_valid = 1'b0;
    endtask

    task automatic w_phase();
        int g;
        logic [47:0] a;
        for (int i = 0; i <= t_lastpos; i++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            req.w_valid = 1'b0;
            repeat (g) @(negedge clk);
            req.w.data  = t_wdata[i];
            req.w.strb  = t_wstrb[i];
            req.w.last  = (i == t_lastpos);
            req.w_valid = 1'b1;
            #1 chk("w_ready", resp.w_ready, 1);
            @(posedge clk);
            a = beat_addr(i);
            if (!no_acc() && in_rng(a))
                for (int b = 0; b < 8; b++)
                    if (t_wstrb[i][b]) ref_mem[widx(a)][b*8 +: 8] = t_wdata[i][b*8 +: 8];
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        #1;
        chk("b_valid_lat", resp.b_valid, 1);
        chk("b_id", resp.b.id, t_id);
        chk("b_resp", resp.b.resp, exp_bresp());
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1 chk("b_hold", {resp.b_valid, resp.b.resp}, {1'b1, exp_bresp()});
        end
        req.b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.b_ready = 1'b0;
        #1 chk("b_done", resp.b_valid, 0);
    endtask

    // mode 0: random r_ready, 1: toggle starting high, other: always ready
    task automatic r_phase(input int mode);
        int          i = 0;
        int          cyc = 0;
        bit          rdy;
        bit          el;
        logic [47:0] a;
        logic [63:0] ed;
        logic [1:0]  er;
        while (i <= int'(t_len)) begin
            case (mode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'b1;
            endcase
            req.r_ready = rdy;
            #1;
            a  = beat_addr(i);
            el = (i == int'(t_len));
            if (!in_rng(a))  begin ed = '0; er = 2'b11; end
            else if (no_acc()) begin ed = '0; er = 2'b10; end
            else begin ed = ref_mem[widx(a)]; er = 2'b00; end
            chk("r_valid", resp.r_valid, 1);
            chk("r_data", resp.r.data, ed);
            chk("r_id_resp_last", {resp.r.id, resp.r.resp, resp.r.last}, {t_id, er, el});
            @(posedge clk);
            if (rdy) i++;
            if (++cyc > 2000) give_up("r_beats");
            @(negedge clk);
        end
        req.r_ready = 1'b0;
        #1 chk("r_end", resp.r_valid, 0);
    endtask

    task automatic do_write();
        aw_phase();
        w_phase();
    endtask

    task automatic do_read(input int mode);
        ar_phase();
        r_phase(mode);
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [2:0]  sz;
        logic [47:0] ad;
        logic [1:0]  bu;
        int          r;
        rst = 1'b1;
        req = '0;
        do_reset();

        // array is clear after reset
        set_t(4'd1, BASE, 8'd3, 3'd3, INCR);
        do_read(2);

        // single write then readback
        set_t(4'd5, BASE + 48'd8, 8'd0, 3'd3, INCR);
        t_wdata[0] = 64'hDEAD_BEEF_0123_4567;
        do_write();
        do_read(2);

        // strobed INCR burst
        set_t(4'd2, BASE, 8'd3, 3'd3, INCR);
        t_wstrb[1] = 8'h0F;
        do_write();
        t_id = 4'd3;
        do_read(2);

        // backpressure: toggling r_ready over 8 beats
        set_t(4'd4, BASE, 8'd7, 3'd3, INCR);
        do_read(1);

        // errors
        set_t(4'd6, BASE + RANGE, 8'd0, 3'd3, INCR);
        do_read(2);
        set_t(4'd7, BASE + 48'd32, 8'd3, 3'd3, WRAP);
        do_write();
        set_t(4'd8, BASE + 48'd32, 8'd3, 3'd3, INCR);
        do_read(2);
        set_t(4'd9, BASE + 48'd64, 8'd3, 3'd3, INCR);
        t_lastpos = 1;
        do_write();
        t_lastpos = 3;
        do_read(2);
        set_t(4'd10, BASE + RANGE + 48'd8, 8'd1, 3'd3, WRAP);
        do_write();
        set_t(4'd11, BASE + RANGE - 48'd16, 8'd3, 3'd3, INCR);
        do_write();
        do_read(2);
        set_t(4'd12, BASE - 48'd8, 8'd1, 3'd3, INCR);
        do_read(2);
        set_t(4'd13, BASE + 48'd96, 8'd0, 3'd3, INCR);
        t_atop = 6'h20;
        do_write();
        t_atop = 6'd0;
        do_read(2);
        set_t(4'd14, BASE + 48'd104, 8'd1, 3'd4, INCR);
        do_write();
        set_t(4'd14, BASE + 48'd104, 8'd1, 3'd3, INCR);
        do_read(2);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
            ad = BASE + ((48'($urandom_range(0, 2047 + 64))) & ~((48'd1 << sz) - 48'd1));
            if ($urandom_range(0, 9) == 0) ad = BASE - 48'd8;
            r  = int'($urandom_range(0, 9));
            bu = (r == 0) ? FIXED : ((r == 1) ? WRAP : INCR);
            set_t(4'($urandom), ad, 8'($urandom_range(0, 7)), sz, bu);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) t_wstrb[i] = 8'($urandom);
                do_write();
            end else begin
                do_read(0);
            end
        end

        // arbitration: collision right after reset, then again after a read grant
        do_reset();
        set_t(4'd2, BASE + 48'd40, 8'd0, 3'd3, INCR);
        drive_ar();
        set_t(4'd1, BASE + 48'd40, 8'd0, 3'd3, INCR);
        drive_aw();
        #1;
        chk("coll1_aw_ready", resp.aw_ready, 1);
        chk("coll1_ar_ready", resp.ar_ready, 0);
        aw_phase();
        w_phase();
        set_t(4'd2, BASE + 48'd40, 8'd0, 3'd3, INCR);
        #1 chk("coll1_ar_next", resp.ar_ready, 1);
        ar_phase();
        r_phase(2);
        set_t(4'd4, BASE + 48'd48, 8'd0, 3'd3, INCR);
        drive_ar();
        set_t(4'd3, BASE + 48'd48, 8'd0, 3'd3, INCR);
        drive_aw();
        #1;
        chk("coll2_aw_ready", resp.aw_ready, 1);
        chk("coll2_ar_ready", resp.ar_ready, 0);
        aw_phase();
        w_phase();
        set_t(4'd4, BASE + 48'd48, 8'd0, 3'd3, INCR);
        ar_phase();
        r_phase(2);

        // reset during beat 2 of a len=3 write
        set_t(4'd5, BASE + 48'd128, 8'd3, 3'd3, INCR);
        aw_phase();
        req.w.data  = t_wdata[0];
        req.w.strb  = 8'hFF;
        req.w.last  = 1'b0;
        req.w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.w.data   = t_wdata[1];
        rst          = 1'b1;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 chk("mid_rst_outs", {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid}, 0);
        req = '0;
        rst = 1'b0;
        req.b_ready = 1'b1;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        repeat (4) begin
            @(negedge clk);
            #1 chk("mid_rst_no_b", {resp.b_valid, resp.r_valid, resp.w_ready}, 0);
        end
        req.b_ready = 1'b0;
        set_t(4'd6, BASE, 8'd255, 3'd3, INCR);
        do_read(2);

        print_summary();
        $finish;
    end

endmodule
